// File: rtl/setpoint_pacer_if.sv
// Host write handshake into the setpoint pacer FIFO.
interface setpoint_pacer_if #(
  parameter int DW = 17
);
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;

  // Host side: drives the setpoint and its valid, watches ready.
  modport master (
    output wr_data,
    output wr_valid,
    input  wr_ready
  );

  // Pacer side: takes the setpoint, reports FIFO space.
  modport slave (
    input  wr_data,
    input  wr_valid,
    output wr_ready
  );
endinterface

// File: rtl/setpoint_pacer.sv
// Setpoint pacer: buffers host setpoints in a small FIFO and releases one
// every PERIOD cycles as a registered strobe plus value for the interpolator.
module setpoint_pacer #(
  parameter int PERIOD = 350,
  parameter int CNTW   = 9,
  parameter int DW     = 17,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              err_clr,
  setpoint_pacer_if.slave   wr,
  output logic [DW-1:0]     y_out,
  output logic              strobe,
  output logic [CNTW-1:0]   phase,
  output logic [AW:0]       fill,
  output logic              underrun
);

  localparam logic [CNTW-1:0] PHASE_LAST = CNTW'(PERIOD - 1);
  localparam int              DEPTH      = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          tick;
  logic          push;
  logic          pop;

  // FIFO status decoded straight from the pointer registers.
  always_comb begin
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    empty = (wr_ptr == rd_ptr);
    fill  = wr_ptr - rd_ptr;
    tick  = enable && (phase == PHASE_LAST);
    push  = wr.wr_valid && !full;
    // An empty FIFO never falls through: a same-cycle push is only stored.
    pop   = tick && !empty;
    wr.wr_ready = !full;
  end

  // Phase counter: free-runs 0..PERIOD-1 while enabled, parked at 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (!enable || tick) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  // Storage array; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr.wr_data;
    end
  end

  // Read/write pointers with one extra wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Output stage: strobe every tick; value advances only when data was waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe <= 1'b0;
      y_out  <= '0;
    end else begin
      strobe <= tick;
      if (pop) begin
        y_out <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // Sticky underrun flag; a fresh underrun beats a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
    end else if (tick && empty) begin
      underrun <= 1'b1;
    end else if (err_clr) begin
      underrun <= 1'b0;
    end
  end

endmodule
